routed_dot_mac: RTL and testbench

//   Downstream consumer of the router/buffer stage (memory_top). Captures the packed

---
 rtl/routed_dot_mac.sv | 145 ++++++++++++++
 tb/tb_routed_dot_mac.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/routed_dot_mac.sv
// routed_dot_mac: captures a routed MaxWidth-lane vector on the rising edge of
// routeDone and computes its signed dot product with a held weight vector, one
// lane per cycle. The result is offered on a valid/ready handshake.
// Optional build macro: ROUTED_DOT_RELU_EN (clamp negative results to zero).
module routed_dot_mac #(
  parameter int unsigned MaxWidth  = 9,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned CntWidth  = $clog2(MaxWidth + 1),
  parameter int unsigned AccWidth  = 2 * DataWidth + $clog2(MaxWidth)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          weightLoadEn,
  input  logic [MaxWidth*DataWidth-1:0] weightIn,
  input  logic                          routeDone,
  input  logic [MaxWidth*DataWidth-1:0] dataIn,
  input  logic [CntWidth-1:0]           laneCount,
  output logic                          busy,
  output logic                          resultValid,
  input  logic                          resultReady,
  output logic [AccWidth-1:0]           result
);

  localparam int unsigned VecWidth  = MaxWidth * DataWidth;
  localparam int unsigned ProdWidth = 2 * DataWidth;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                route_done_q;
  logic [VecWidth-1:0] data_q, data_d;
  logic [VecWidth-1:0] weight_q, weight_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic [CntWidth-1:0] idx_q, idx_d;
  logic [AccWidth-1:0] acc_q, acc_d;
  logic [AccWidth-1:0] result_d;
  logic                valid_d;
  logic                busy_d;

  logic                        start;
  logic [CntWidth-1:0]         count_clamp;
  logic signed [DataWidth-1:0] data_lane;
  logic signed [DataWidth-1:0] weight_lane;
  logic signed [ProdWidth-1:0] prod;
  logic [AccWidth-1:0]         prod_ext;
  logic [AccWidth-1:0]         acc_sum;

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    weight_d = weight_q;
    count_d  = count_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result;
    valid_d  = resultValid;

    start       = routeDone & ~route_done_q;
    count_clamp = (laneCount > CntWidth'(MaxWidth)) ? CntWidth'(MaxWidth) : laneCount;

    data_lane   = '0;
    weight_lane = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (idx_q == CntWidth'(i)) begin
        data_lane   = data_q[i*DataWidth +: DataWidth];
        weight_lane = weight_q[i*DataWidth +: DataWidth];
      end
    end
    prod     = data_lane * weight_lane;
    prod_ext = {{(AccWidth - ProdWidth){prod[ProdWidth-1]}}, prod};
    acc_sum  = acc_q + prod_ext;

    case (state_q)
      IDLE: begin
        if (weightLoadEn) weight_d = weightIn;
        if (start) begin
          data_d  = dataIn;
          count_d = count_clamp;
          idx_d   = '0;
          acc_d   = '0;
          if (count_clamp == '0) begin
            state_d  = HOLD;
            result_d = '0;
            valid_d  = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        idx_d = idx_q + CntWidth'(1);
        if (idx_q == count_q - CntWidth'(1)) begin
          state_d = HOLD;
          valid_d = 1'b1;
`ifdef ROUTED_DOT_RELU_EN
          result_d = acc_sum[AccWidth-1] ? '0 : acc_sum;
`else
          result_d = acc_sum;
`endif
        end
      end
      HOLD: begin
        if (resultValid && resultReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      route_done_q <= 1'b0;
      data_q       <= '0;
      weight_q     <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      result       <= '0;
      resultValid  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      route_done_q <= routeDone;
      data_q       <= data_d;
      weight_q     <= weight_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      result       <= result_d;
      resultValid  <= valid_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_routed_dot_mac.sv
// tb_routed_dot_mac: directed and randomized checks of routed_dot_mac against
// an arithmetic dot-product model. Honours ROUTED_DOT_RELU_EN when defined.
module tb_routed_dot_mac;

  localparam int MW = 9;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int AW = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic            weightLoadEn;
  logic [MW*DW-1:0] weightIn;
  logic            routeDone;
  logic [MW*DW-1:0] dataIn;
  logic [CW-1:0]   laneCount;
  logic            busy;
  logic            resultValid;
  logic            resultReady;
  logic [AW-1:0]   result;

  int total = 0;
  int bad   = 0;

  byte wmodel[MW];
  byte wnew[MW];
  byte dv[MW];

  always #5 clk = ~clk;

  routed_dot_mac dut (
    .clk(clk), .rst(rst), .weightLoadEn(weightLoadEn), .weightIn(weightIn),
    .routeDone(routeDone), .dataIn(dataIn), .laneCount(laneCount), .busy(busy),
    .resultValid(resultValid), .resultReady(resultReady), .result(result)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected dot product from the model arrays, truncated to the result width
  function automatic logic [AW-1:0] model(input int cnt);
    longint s = 0;
    int n = (cnt > MW) ? MW : cnt;
    for (int i = 0; i < n; i++) s += longint'(wmodel[i]) * longint'(dv[i]);
`ifdef ROUTED_DOT_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[AW-1:0];
  endfunction

  task automatic drive_w();
    for (int i = 0; i < MW; i++) weightIn[i*DW +: DW] = wnew[i];
  endtask

  task automatic drive_d();
    for (int i = 0; i < MW; i++) dataIn[i*DW +: DW] = dv[i];
  endtask

  task automatic load_weights();
    drive_w();
    weightLoadEn = 1'b1;
    step();
    weightLoadEn = 1'b0;
    for (int i = 0; i < MW; i++) wmodel[i] = wnew[i];
  endtask

  // One full transaction: start edge, latency, result, optional backpressure, accept
  task automatic run(input string tag, input int cnt, input bit load_now, input int ready_delay);
    int n;
    int n_exp;
    logic [AW-1:0] exp;
    drive_d();
    laneCount = CW'(cnt);
    if (load_now) begin
      drive_w();
      weightLoadEn = 1'b1;
      for (int i = 0; i < MW; i++) wmodel[i] = wnew[i];
    end
    routeDone = 1'b1;
    step();
    routeDone    = 1'b0;
    weightLoadEn = 1'b0;
    exp   = model(cnt);
    n_exp = (cnt > MW) ? MW : cnt;
    check({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!resultValid && n < 40) begin
      step();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(n_exp));
    check({tag, " result"}, 32'(result), 32'(exp));
    for (int k = 0; k < ready_delay; k++) begin
      step();
      check({tag, " held valid"}, 32'(resultValid), 32'd1);
      check({tag, " held result"}, 32'(result), 32'(exp));
    end
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
    check({tag, " valid drop"}, 32'(resultValid), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] bp_exp;
    int cnt;
    rst = 1'b1;
    weightLoadEn = 1'b0;
    weightIn = '0;
    routeDone = 1'b0;
    dataIn = '0;
    laneCount = '0;
    resultReady = 1'b0;
    for (int i = 0; i < MW; i++) begin wmodel[i] = 0; wnew[i] = 0; dv[i] = 0; end
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(resultValid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    rst = 1'b0;
    step();

    // 1: unit weights, data 1..9 -> 45
    for (int i = 0; i < MW; i++) begin wnew[i] = 8'sd1; dv[i] = byte'(i + 1); end
    load_weights();
    run("t1", 9, 1'b0, 0);
    check("t1 value", 32'(model(9)), 32'h0002D);

    // 2: weights 2, data -1 -> -18
    for (int i = 0; i < MW; i++) begin wnew[i] = 8'sd2; dv[i] = -8'sd1; end
    load_weights();
    run("t2", 9, 1'b0, 0);

    // 3: zero lanes and clamped lane count
    run("t3 zero", 0, 1'b0, 0);
    for (int i = 0; i < MW; i++) dv[i] = byte'(3 * i - 7);
    run("t3 clamp", 12, 1'b0, 0);

    // 4: worst case magnitude, weights loaded in the start cycle
    for (int i = 0; i < MW; i++) begin wnew[i] = -8'sd128; dv[i] = -8'sd128; end
    run("t4", 9, 1'b1, 0);

    // 5: backpressure with ignored start edge and ignored weight load in HOLD
    for (int i = 0; i < MW; i++) begin wnew[i] = 8'sd3; dv[i] = byte'($urandom); end
    load_weights();
    drive_d();
    laneCount = CW'(5);
    routeDone = 1'b1;
    step();
    routeDone = 1'b0;
    bp_exp = model(5);
    cnt = 0;
    while (!resultValid && cnt < 40) begin step(); cnt++; end
    check("t5 latency", 32'(cnt), 32'd5);
    for (int i = 0; i < MW; i++) wnew[i] = 8'sd7;
    drive_w();
    weightLoadEn = 1'b1;
    routeDone = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5 held valid", 32'(resultValid), 32'd1);
      check("t5 held result", 32'(result), 32'(bp_exp));
    end
    weightLoadEn = 1'b0;
    resultReady = 1'b1;
    step();
    resultReady = 1'b0;
    check("t5 valid drop", 32'(resultValid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5 held routeDone no restart", 32'(busy), 32'd0);
    end
    routeDone = 1'b0;
    step();
    for (int i = 0; i < MW; i++) dv[i] = byte'($urandom);
    run("t5 old weights", 9, 1'b0, 0);

    // 6: reset during ACCUM lane 4, weights cleared afterwards
    for (int i = 0; i < MW; i++) dv[i] = byte'(i + 10);
    drive_d();
    laneCount = CW'(9);
    routeDone = 1'b1;
    step();
    routeDone = 1'b0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    check("t6 async busy", 32'(busy), 32'd0);
    check("t6 async valid", 32'(resultValid), 32'd0);
    check("t6 async result", 32'(result), 32'd0);
    #1 rst = 1'b0;
    step();
    for (int i = 0; i < MW; i++) wmodel[i] = 0;
    run("t6 cleared weights", 9, 1'b0, 0);
    for (int i = 0; i < MW; i++) wnew[i] = byte'(i - 4);
    load_weights();
    run("t6 reloaded", 9, 1'b0, 0);

    // Randomized transactions
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < MW; i++) begin
        wnew[i] = byte'($urandom);
        dv[i]   = byte'($urandom);
      end
      cnt = $urandom_range(0, 15);
      run("rand", cnt, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
